// File: rtl/rep_code_tx.sv
// rtl/rep_code_tx.sv - 4x repetition-coded serial transmitter (start, LSB-first data, even parity, stop)
module rep_code_tx #(
    parameter int DATA_W = 8,
    parameter int REP    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);

    localparam int RW = (REP > 1) ? $clog2(REP) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state;
    logic [RW-1:0]     rep_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nx;
    logic              parity;

    assign din_ready = (state == IDLE);
    assign shreg_nx  = shreg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rep_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            parity  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (din_valid) begin
                    shreg   <= din;
                    parity  <= ^din;
                    state   <= START;
                    tx_out  <= 1'b0;
                    busy    <= 1'b1;
                    rep_cnt <= '0;
                end
            end else if (rep_cnt != REP_LAST) begin
                rep_cnt <= rep_cnt + RW'(1);
            end else begin
                // Symbol boundary: present the next symbol for the following REP cycles
                rep_cnt <= '0;
                case (state)
                    START: begin
                        state   <= DATA;
                        tx_out  <= shreg[0];
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg <= shreg_nx;
                        if (bit_cnt == BIT_LAST) begin
                            state  <= PARITY;
                            tx_out <= parity;
                        end else begin
                            tx_out  <= shreg_nx[0];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                    default: begin
                        state  <= IDLE;
                        tx_out <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rep_code_tx.sv
// tb/tb_rep_code_tx.sv - directed self-checking bench for rep_code_tx
module tb_rep_code_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, tx_out, busy, done;

    logic       din1, din_valid1;
    logic       din_ready1, tx_out1, busy1, done1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cyc = 0;
    int prev_done_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rep_code_tx #(.DATA_W(8), .REP(4)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx_out(tx_out), .busy(busy), .done(done)
    );

    rep_code_tx #(.DATA_W(1), .REP(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din1), .din_valid(din_valid1),
        .din_ready(din_ready1), .tx_out(tx_out1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_tx(input logic [7:0] w, input int k);
        int sym;
        sym = k / 4;
        if (sym == 0) return 1'b0;
        if (sym <= 8) return w[sym-1];
        if (sym == 9) return ^w;
        return 1'b1;
    endfunction

    // Called just after a negedge; the following posedge is the accept edge.
    task automatic start(input logic [7:0] w, input logic hold);
        din = w;
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] w, input logic hold, input logic [7:0] nxt,
                             input logic disturb);
        start(w, hold);
        if (hold) din = nxt;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            check("frame_bits", {28'd0, tx_out, busy, done, din_ready},
                  {28'd0, exp_tx(w, k), 1'b1, 1'b0, 1'b0});
            if (disturb && k >= 4 && k < 36) begin
                din = 8'($urandom);
                din_valid = k[0];
            end
        end
        din_valid = hold;
        @(negedge clk);
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
        check("frame_end", {28'd0, tx_out, busy, done, din_ready}, {28'd0, 4'b1011});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        din1 = 1'b0;
        din_valid1 = 1'b0;
        #12;
        check("reset_state", {28'd0, tx_out, busy, done, din_ready}, {28'd0, 4'b1001});
        check("reset_state1", {28'd0, tx_out1, busy1, done1, din_ready1}, {28'd0, 4'b1001});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(8'hA5, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        run_frame(8'h07, 1'b0, 8'h00, 1'b0);
        run_frame(8'h00, 1'b0, 8'h00, 1'b0);

        run_frame(8'h3C, 1'b1, 8'hC3, 1'b0);
        run_frame(8'hC3, 1'b0, 8'h00, 1'b0);
        check("b2b_done_spacing", done_cyc - prev_done_cyc, 32'd45);

        run_frame(8'h96, 1'b0, 8'h00, 1'b1);

        // Asynchronous reset between edges during the DATA phase
        start(8'hFF, 1'b0);
        repeat (10) @(negedge clk);
        check("pre_reset_tx", {31'd0, tx_out}, 32'd1);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {28'd0, tx_out, busy, done, din_ready}, {28'd0, 4'b1001});
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {28'd0, tx_out, busy, done, din_ready}, {28'd0, 4'b1001});
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_idle", {28'd0, tx_out, busy, done, din_ready}, {28'd0, 4'b1001});
        end
        run_frame(8'h5A, 1'b0, 8'h00, 1'b0);

        // DATA_W=1, REP=1: 0,1,1,1 then done
        din1 = 1'b1;
        din_valid1 = 1'b1;
        @(posedge clk);
        #1;
        din_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("small_frame", {29'd0, tx_out1, busy1, done1},
                  {29'd0, (k == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        check("small_done", {28'd0, tx_out1, busy1, done1, din_ready1}, {28'd0, 4'b1011});
        @(negedge clk);
        check("small_done_drop", {31'd0, done1}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
